// File: rtl/h75_bcm_scan_engine.sv
// HUB75 scan/timing engine with binary-code-modulated output enable.
//
// Walks a frame plane by plane (MSB plane first) and row by row. For each row it
// issues frame-buffer read addresses, turns the RAM read strobe into rd_valid and
// a registered led_clk, then waits for the previous row's OE window to close,
// blanks for a guard interval, switches the row select, latches and starts the
// new OE window. Shifting of the next row overlaps the current OE window.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   gen_timing           run enable, sampled only when idle
//   pixels_per_row       shift length per row (0 behaves as 1)
//   min_plane            lowest displayed plane (clamped to NUM_PLANES-1)
//   brightness           global on-time scale, 0..255
//   frame_sync           high during the frame start delay
//   plane                current bit plane
//   rd_addr              {y, x} frame buffer read address
//   rd_valid             RAM data for the current pixel valid
//   led_clk              registered shift clock, one cycle after rd_valid
//   latch_enable         panel latch
//   oe                   active-low output enable
//   ABCDE                row select
//   frame_done           one-cycle pulse at frame end
//   busy                 high from frame start until frame_done
module h75_bcm_scan_engine #(
  parameter int unsigned ROW_BITS          = 5,
  parameter int unsigned COL_BITS          = 9,
  parameter int unsigned NUM_PLANES        = 8,
  parameter int unsigned RD_LATENCY        = 2,
  parameter int unsigned FRAME_START_DELAY = 10,
  parameter int unsigned BCM_PAD           = 6,
  parameter int unsigned LATCH_CYCLES      = 1,
  parameter int unsigned GHOST_CYCLES      = 4,
  localparam int unsigned PW               = $clog2(NUM_PLANES)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         gen_timing,
  input  logic [COL_BITS-1:0]          pixels_per_row,
  input  logic [PW-1:0]                min_plane,
  input  logic [7:0]                   brightness,
  output logic                         frame_sync,
  output logic [PW-1:0]                plane,
  output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
  output logic                         rd_valid,
  output logic                         led_clk,
  output logic                         latch_enable,
  output logic                         oe,
  output logic [ROW_BITS-1:0]          ABCDE,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int unsigned OnW       = COL_BITS + NUM_PLANES + 1;
  localparam int unsigned ProdW     = OnW + 8;
  localparam int unsigned CntW      = 16;
  localparam int unsigned StartLast = (FRAME_START_DELAY > 0) ? FRAME_START_DELAY - 1 : 0;
  localparam int unsigned GhostLast = (GHOST_CYCLES > 0) ? GHOST_CYCLES - 1 : 0;

  typedef enum logic [3:0] {
    StIdle, StStart, StShift, StDrain, StWaitOe, StLatch, StOeStart, StNext, StEnd
  } state_e;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic [COL_BITS-1:0]            x_q, x_d;
  logic [ROW_BITS-1:0]            y_q, y_d;
  logic [PW-1:0]                  plane_q, plane_d;
  logic [COL_BITS-1:0]            ppr_q, ppr_d;
  logic [PW-1:0]                  minp_q, minp_d;
  logic [7:0]                     bright_q, bright_d;
  logic                           phase_q, phase_d;
  logic                           strb_q, strb_d;
  logic [RD_LATENCY-1:0]          pipe_q, pipe_d;
  logic                           led_clk_q, led_clk_d;
  logic [ROW_BITS+COL_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic                           fs_q, fs_d;
  logic                           latch_q, latch_d;
  logic                           oe_q, oe_d;
  logic [OnW-1:0]                 oe_cnt_q, oe_cnt_d;
  logic [ROW_BITS-1:0]            abcde_q, abcde_d;
  logic                           done_q, done_d;
  logic                           busy_q, busy_d;

  logic [COL_BITS-1:0]            ppr_in;
  logic [PW-1:0]                  minp_in;
  logic [COL_BITS:0]              base;
  logic [PW-1:0]                  shamt;
  logic [ProdW-1:0]               prod;
  logic [OnW-1:0]                 on_cycles;
  logic                           last_x;
  logic                           last_row;

  // Frame-start capture values.
  always_comb begin
    ppr_in  = (pixels_per_row == '0) ? COL_BITS'(1) : pixels_per_row;
    minp_in = (int'(min_plane) > int'(NUM_PLANES) - 1) ? PW'(NUM_PLANES - 1) : min_plane;
  end

  // On-time of the current plane: ((ppr + pad) << (plane - min_plane)) * brightness / 256.
  always_comb begin
    base      = {1'b0, ppr_q} + (COL_BITS + 1)'(BCM_PAD);
    shamt     = plane_q - minp_q;
    prod      = (ProdW'(base) << shamt) * ProdW'(bright_q);
    on_cycles = OnW'(prod >> 8);
    last_x    = (x_q == ppr_q - COL_BITS'(1));
    last_row  = (y_q == {ROW_BITS{1'b1}});
  end

  // Read strobe delayed by the RAM latency; led_clk trails rd_valid by one cycle.
  always_comb begin
    pipe_d[0] = strb_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    led_clk_d = pipe_q[RD_LATENCY-1];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    plane_d   = plane_q;
    ppr_d     = ppr_q;
    minp_d    = minp_q;
    bright_d  = bright_q;
    phase_d   = phase_q;
    strb_d    = 1'b0;
    rd_addr_d = rd_addr_q;
    fs_d      = fs_q;
    latch_d   = 1'b0;
    abcde_d   = abcde_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    // OE window countdown runs in the background while the next row shifts.
    oe_cnt_d = oe_cnt_q;
    oe_d     = oe_q;
    if (oe_cnt_q != '0) begin
      oe_cnt_d = oe_cnt_q - OnW'(1);
      oe_d     = (oe_cnt_q == OnW'(1));
    end

    unique case (state_q)
      StIdle: begin
        if (gen_timing && oe_q) begin
          ppr_d    = ppr_in;
          minp_d   = minp_in;
          bright_d = brightness;
          busy_d   = 1'b1;
          fs_d     = 1'b1;
          cnt_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntW'(StartLast)) begin
          fs_d    = 1'b0;
          plane_d = PW'(NUM_PLANES - 1);
          y_d     = '0;
          x_d     = '0;
          phase_d = 1'b0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        // Address on even phase, advance x on odd phase: one address per two cycles.
        if (!phase_q) begin
          rd_addr_d = {y_q, x_q};
          strb_d    = 1'b1;
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_x) begin
            state_d = StDrain;
          end else begin
            x_d = x_q + COL_BITS'(1);
          end
        end
      end
      StDrain: begin
        if (!strb_q && (pipe_q == '0) && !led_clk_q) begin
          cnt_d   = '0;
          state_d = StWaitOe;
        end
      end
      StWaitOe: begin
        // Count blanked cycles only once the previous OE window has closed.
        if (!oe_q) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(GhostLast)) begin
          abcde_d = y_q;
          cnt_d   = '0;
          state_d = StLatch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLatch: begin
        if (cnt_q < CntW'(LATCH_CYCLES)) begin
          latch_d = 1'b1;
          cnt_d   = cnt_q + CntW'(1);
        end else begin
          cnt_d   = '0;
          state_d = StOeStart;
        end
      end
      StOeStart: begin
        oe_cnt_d = on_cycles;
        oe_d     = (on_cycles == '0);
        state_d  = StNext;
      end
      StNext: begin
        if (!last_row) begin
          y_d     = y_q + ROW_BITS'(1);
          x_d     = '0;
          phase_d = 1'b0;
          state_d = StShift;
        end else if (plane_q > minp_q) begin
          plane_d = plane_q - PW'(1);
          y_d     = '0;
          x_d     = '0;
          phase_d = 1'b0;
          state_d = StShift;
        end else begin
          state_d = StEnd;
        end
      end
      StEnd: begin
        if (oe_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      plane_q   <= PW'(NUM_PLANES - 1);
      ppr_q     <= COL_BITS'(1);
      minp_q    <= '0;
      bright_q  <= '0;
      phase_q   <= 1'b0;
      strb_q    <= 1'b0;
      pipe_q    <= '0;
      led_clk_q <= 1'b0;
      rd_addr_q <= '0;
      fs_q      <= 1'b0;
      latch_q   <= 1'b0;
      oe_q      <= 1'b1;
      oe_cnt_q  <= '0;
      abcde_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      plane_q   <= plane_d;
      ppr_q     <= ppr_d;
      minp_q    <= minp_d;
      bright_q  <= bright_d;
      phase_q   <= phase_d;
      strb_q    <= strb_d;
      pipe_q    <= pipe_d;
      led_clk_q <= led_clk_d;
      rd_addr_q <= rd_addr_d;
      fs_q      <= fs_d;
      latch_q   <= latch_d;
      oe_q      <= oe_d;
      oe_cnt_q  <= oe_cnt_d;
      abcde_q   <= abcde_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign frame_sync   = fs_q;
  assign plane        = plane_q;
  assign rd_addr      = rd_addr_q;
  assign rd_valid     = pipe_q[RD_LATENCY-1];
  assign led_clk      = led_clk_q;
  assign latch_enable = latch_q;
  assign oe           = oe_q;
  assign ABCDE        = abcde_q;
  assign frame_done   = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_h75_bcm_scan_engine.sv
module tb_h75_bcm_scan_engine;

  localparam int RowBits   = 5;
  localparam int ColBits   = 9;
  localparam int NumPlanes = 8;
  localparam int RdLat     = 3;
  localparam int Ghost     = 4;
  localparam int LatchCyc  = 1;
  localparam int StartDly  = 10;
  localparam int BcmPad    = 6;
  localparam int Rows      = 1 << RowBits;
  localparam int AW        = RowBits + ColBits;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          gen_timing = 1'b0;
  logic [8:0]    ppr_in = '0;
  logic [2:0]    minp_in = '0;
  logic [7:0]    bright_in = '0;
  logic          frame_sync, rd_valid, led_clk, latch_enable, oe, frame_done, busy;
  logic [2:0]    plane;
  logic [AW-1:0] rd_addr;
  logic [4:0]    ABCDE;

  h75_bcm_scan_engine #(.RD_LATENCY(RdLat)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .gen_timing    (gen_timing),
    .pixels_per_row(ppr_in),
    .min_plane     (minp_in),
    .brightness    (bright_in),
    .frame_sync    (frame_sync),
    .plane         (plane),
    .rd_addr       (rd_addr),
    .rd_valid      (rd_valid),
    .led_clk       (led_clk),
    .latch_enable  (latch_enable),
    .oe            (oe),
    .ABCDE         (ABCDE),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference on-time from the brightness rule, in plain integer arithmetic.
  function automatic int model_on(input int ppr, input int minp, input int bright, input int pl);
    int ppe;
    int mp;
    ppe = (ppr == 0) ? 1 : ppr;
    mp  = (minp > NumPlanes - 1) ? NumPlanes - 1 : minp;
    return ((ppe + BcmPad) * (1 << (pl - mp)) * bright) / 256;
  endfunction

  // Per-frame observations gathered by the monitor.
  int mon_ppe = 1;
  int latch_cnt, rv_in_row, led_in_row, fd_cnt, fs_cnt, oe_len, lat_len;
  int hi_cnt = 1000;
  int oe_runs[$];
  int v_latch_oe, v_abcde_oe, v_ghost, v_ledclk, v_addr, v_rowcnt, v_row, v_plane, v_latchw;
  logic          prev_latch = 1'b0;
  logic          prev_rv = 1'b0;
  logic [4:0]    prev_abcde = '0;
  logic [AW-1:0] hist [RdLat+1];
  logic [AW-1:0] exp_addr;

  task automatic clear_stats();
    latch_cnt = 0; rv_in_row = 0; led_in_row = 0; fd_cnt = 0; fs_cnt = 0;
    v_latch_oe = 0; v_abcde_oe = 0; v_ghost = 0; v_ledclk = 0; v_addr = 0;
    v_rowcnt = 0; v_row = 0; v_plane = 0; v_latchw = 0;
    oe_runs.delete();
  endtask

  initial begin
    for (int j = 0; j <= RdLat; j++) hist[j] = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_latch = 1'b0; prev_rv = 1'b0; prev_abcde = '0;
        hi_cnt = 1000; oe_len = 0; lat_len = 0;
        for (int j = 0; j <= RdLat; j++) hist[j] = '0;
      end else begin
        if (latch_enable && !oe) v_latch_oe++;
        if (oe) hi_cnt++; else hi_cnt = 0;
        if (ABCDE != prev_abcde) begin
          if (!oe) v_abcde_oe++;
          if (hi_cnt - 1 < Ghost) v_ghost++;
        end
        prev_abcde = ABCDE;
        if (!oe) oe_len++;
        else if (oe_len > 0) begin
          oe_runs.push_back(oe_len);
          oe_len = 0;
        end
        if (led_clk != prev_rv) v_ledclk++;
        prev_rv = rd_valid;
        // hist[j] holds rd_addr from j+1 samples ago.
        if (rd_valid) begin
          exp_addr = AW'((latch_cnt % Rows) * (1 << ColBits) + rv_in_row);
          if (hist[RdLat-1] != exp_addr) v_addr++;
          if (rv_in_row > 0 && hist[RdLat] == exp_addr) v_addr++;
          rv_in_row++;
        end
        if (led_clk) led_in_row++;
        for (int j = RdLat; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = rd_addr;
        if (latch_enable && !prev_latch) begin
          if (rv_in_row != mon_ppe || led_in_row != mon_ppe) v_rowcnt++;
          if (int'(ABCDE) != latch_cnt % Rows) v_row++;
          if (int'(plane) != NumPlanes - 1 - latch_cnt / Rows) v_plane++;
          latch_cnt++;
          rv_in_row = 0;
          led_in_row = 0;
        end
        if (latch_enable) lat_len++;
        else if (lat_len > 0) begin
          if (lat_len != LatchCyc) v_latchw++;
          lat_len = 0;
        end
        prev_latch = latch_enable;
        if (frame_done) fd_cnt++;
        if (frame_sync) fs_cnt++;
      end
    end
  end

  task automatic run_frame(input string tag, input int ppr, input int minp, input int bright,
                           input int drop_at, input int exp_lat, input int exp_first,
                           input int exp_last);
    int exp_runs[$];
    int mp, t, mism;
    mp = (minp > NumPlanes - 1) ? NumPlanes - 1 : minp;
    for (int pl = NumPlanes - 1; pl >= mp; pl--) begin
      for (int r = 0; r < Rows; r++) begin
        if (model_on(ppr, minp, bright, pl) > 0) exp_runs.push_back(model_on(ppr, minp, bright, pl));
      end
    end
    @(negedge clk);
    clear_stats();
    mon_ppe    = (ppr == 0) ? 1 : ppr;
    ppr_in     = 9'(ppr);
    minp_in    = 3'(minp);
    bright_in  = 8'(bright);
    gen_timing = 1'b1;
    t = 0;
    while (!busy && t < 100) begin @(negedge clk); t++; end
    check({tag, " busy at start"}, busy, 1);
    if (drop_at >= 0) begin
      t = 0;
      while (latch_cnt < drop_at && t < 60000) begin @(negedge clk); t++; end
    end
    gen_timing = 1'b0;
    // Inputs are captured at frame start; scrambling them now must not matter.
    ppr_in    = 9'($urandom_range(0, 511));
    minp_in   = 3'($urandom_range(0, 7));
    bright_in = 8'($urandom_range(0, 255));
    t = 0;
    while (fd_cnt == 0 && t < 80000) begin @(negedge clk); t++; end
    repeat (20) @(negedge clk);
    check({tag, " frame_done pulses"}, fd_cnt, 1);
    check({tag, " busy after"}, busy, 0);
    check({tag, " latches"}, latch_cnt, exp_lat);
    check({tag, " frame_sync cycles"}, fs_cnt, StartDly);
    check({tag, " oe run count"}, oe_runs.size(), exp_runs.size());
    mism = 0;
    for (int i = 0; i < exp_runs.size() && i < oe_runs.size(); i++) begin
      if (oe_runs[i] != exp_runs[i]) mism++;
    end
    check({tag, " oe run lengths wrong"}, mism, 0);
    if (oe_runs.size() > 0) begin
      check({tag, " first oe run"}, oe_runs[0], exp_first);
      check({tag, " last oe run"}, oe_runs[oe_runs.size()-1], exp_last);
    end
    check({tag, " latch while oe low"}, v_latch_oe, 0);
    check({tag, " row change while oe low"}, v_abcde_oe, 0);
    check({tag, " ghost gap short"}, v_ghost, 0);
    check({tag, " led_clk not after rd_valid"}, v_ledclk, 0);
    check({tag, " rd_valid address/latency"}, v_addr, 0);
    check({tag, " pulses per row"}, v_rowcnt, 0);
    check({tag, " row select order"}, v_row, 0);
    check({tag, " plane order"}, v_plane, 0);
    check({tag, " latch width"}, v_latchw, 0);
  endtask

  typedef struct {
    int ppr;
    int minp;
    int bright;
    int drop_at;
    int exp_lat;
    int exp_first;
    int exp_last;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int t;
    int rp, rm, rb;
    vecs[0] = '{64, 7, 255, -1, 32, 69, 69};
    vecs[1] = '{1, 7, 0, -1, 32, 0, 0};
    vecs[2] = '{0, 6, 255, -1, 64, 13, 6};
    vecs[3] = '{64, 6, 128, -1, 64, 70, 35};
    vecs[4] = '{20, 4, 64, 74, 128, 52, 6};

    // Reset values.
    #5 resetn = 1'b0;
    #20;
    check("reset frame_sync", frame_sync, 0);
    check("reset plane", plane, 7);
    check("reset rd_addr", rd_addr, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset led_clk", led_clk, 0);
    check("reset latch", latch_enable, 0);
    check("reset oe", oe, 1);
    check("reset ABCDE", ABCDE, 0);
    check("reset frame_done", frame_done, 0);
    check("reset busy", busy, 0);
    @(negedge clk);
    #2 resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Long plane-7 window, then reset while OE is low and the next row shifts.
    clear_stats();
    mon_ppe    = 64;
    ppr_in     = 9'd64;
    minp_in    = 3'd2;
    bright_in  = 8'd255;
    gen_timing = 1'b1;
    t = 0;
    while (!busy && t < 100) begin @(negedge clk); t++; end
    gen_timing = 1'b0;
    t = 0;
    while ((oe_runs.size() == 0 || !(oe == 1'b0 && rd_valid == 1'b1)) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("plane7 on_cycles", (oe_runs.size() > 0) ? oe_runs[0] : -1, 2231);
    check("oe low before reset", oe, 0);
    check("rd_valid before reset", rd_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("mid reset oe", oe, 1);
    check("mid reset led_clk", led_clk, 0);
    check("mid reset rd_valid", rd_valid, 0);
    check("mid reset ABCDE", ABCDE, 0);
    check("mid reset busy", busy, 0);
    check("mid reset plane", plane, 7);
    repeat (3) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("idle after reset busy", busy, 0);
    check("idle after reset frame_sync", frame_sync, 0);

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].ppr, vecs[i].minp, vecs[i].bright,
                vecs[i].drop_at, vecs[i].exp_lat, vecs[i].exp_first, vecs[i].exp_last);
    end

    for (int i = 0; i < 2; i++) begin
      rp = $urandom_range(0, 30);
      rm = $urandom_range(5, 7);
      rb = $urandom_range(0, 255);
      run_frame($sformatf("rand%0d", i), rp, rm, rb, -1, (NumPlanes - rm) * Rows,
                model_on(rp, rm, rb, NumPlanes - 1), model_on(rp, rm, rb, rm));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
